// File: rtl/mem_access_unit_if.sv
// CPU/memory bus bundle for the load/store engine.
// The slave view belongs to mem_access_unit; the master view is the CPU
// plus data-memory side that drives requests and supplies read data.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       pc;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              exc_adel;
  logic              exc_ades;
  logic [ADDR_W-1:0] mem_A;
  logic              mem_WE;
  logic [31:0]       mem_WD;
  logic [31:0]       mem_RD;
  logic [31:0]       mem_pc;

  modport slave (
    input  req, op, addr, wdata, pc, mem_RD,
    output busy, done, rdata, exc_adel, exc_ades, mem_A, mem_WE, mem_WD, mem_pc
  );

  modport master (
    output req, op, addr, wdata, pc, mem_RD,
    input  busy, done, rdata, exc_adel, exc_ades, mem_A, mem_WE, mem_WD, mem_pc
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS load/store engine in front of a word-addressed
// data memory (combinational read, synchronous word write). Sub-word
// stores are done as read-modify-write through a one-word buffer.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // Stores occupy the top three opcodes.
  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SW);
  endfunction

  // Word accesses need addr[1:0]==0, halves need addr[0]==0, bytes never fault.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic r;
    case (op)
      OP_LW, OP_SW:         r = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: r = lo[0];
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  // Pick the addressed little-endian lane and sign/zero-extend it.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] op,
                                                    input logic [1:0] lo,
                                                    input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] shifted;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] res;
    shifted = word >> {lo, 3'b000};
    b       = shifted[7:0];
    h       = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LH:   res = {{16{h[15]}}, h};
      OP_LHU:  res = {16'h0000, h};
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LBU:  res = {24'h00_0000, b};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of the buffered word with the store data.
  function automatic logic [DATA_W-1:0] store_merge(input logic [2:0] op,
                                                    input logic [1:0] lo,
                                                    input logic [DATA_W-1:0] buffer,
                                                    input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] res;
    res = buffer;
    case (op)
      OP_SB: begin
        case (lo)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      OP_SH: begin
        if (lo[1]) res[31:16] = wd[15:0];
        else       res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [31:0]         pc_q, pc_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                adel_q, adel_d;
  logic                ades_q, ades_d;
  logic                mem_we_s;
  logic [DATA_W-1:0]   mem_wd_s;

  // Next-state and datapath updates for the request/access/write/response sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    buf_d   = buf_q;
    adel_d  = adel_q;
    ades_d  = ades_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          op_d    = bus.op;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          pc_d    = bus.pc;
          if (misaligned(bus.op, bus.addr[1:0])) begin
            if (is_store(bus.op)) ades_d = 1'b1;
            else                  adel_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!is_store(op_q)) begin
          rdata_d = load_extend(op_q, addr_q[1:0], bus.mem_RD);
          state_d = ST_RESP;
        end else if (op_q == OP_SW) begin
          state_d = ST_RESP;
        end else begin
          buf_d   = bus.mem_RD;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write strobe and data decoded from registered state only, so reset kills them at once.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wd_s = {DATA_W{1'b0}};
    if (state_q == ST_ACCESS && op_q == OP_SW) begin
      mem_we_s = 1'b1;
      mem_wd_s = wdata_q;
    end else if (state_q == ST_WRITE) begin
      mem_we_s = 1'b1;
      mem_wd_s = store_merge(op_q, addr_q[1:0], buf_q, wdata_q);
    end else begin
      mem_we_s = 1'b0;
      mem_wd_s = {DATA_W{1'b0}};
    end
  end

  // State and latched request registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      pc_q    <= 32'd0;
      rdata_q <= {DATA_W{1'b0}};
      buf_q   <= {DATA_W{1'b0}};
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      buf_q   <= buf_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_RESP);
  assign bus.rdata    = rdata_q;
  assign bus.exc_adel = adel_q;
  assign bus.exc_ades = ades_q;
  assign bus.mem_A    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_WE   = mem_we_s;
  assign bus.mem_WD   = mem_wd_s;
  assign bus.mem_pc   = pc_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store engine between the CPU datapath and the word-addressed data memory.
- The memory has a combinational read port, a synchronous write port, and word-only writes.
- Handles all MIPS load/store widths (lw/lh/lhu/lb/lbu/sw/sh/sb), checks alignment, sign/zero-extends loads, and performs sub-word stores as read-modify-write.
- Presents a req/done handshake to the CPU and stalls it via busy.

Parameters:
- ADDR_W, 32, byte-address width of CPU and memory addresses.
- DATA_W, 32, data width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  CPU request strobe; sampled only in IDLE.
- op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data (low byte/half used for sb/sh).
- pc  input  32  PC of the issuing instruction.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result; valid while done=1, held until next load completes.
- exc_adel  output  1  misaligned load; valid with done.
- exc_ades  output  1  misaligned store; valid with done.
- mem_A  output  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}.
- mem_WE  output  1  memory write enable.
- mem_WD  output  32  memory write data.
- mem_RD  input  32  memory combinational read data.
- mem_pc  output  32  latched pc, forwarded to memory for write logging.

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - busy, done, rdata, exc_adel, exc_ades, mem_WE, mem_WD, mem_A, mem_pc all 0.
- mem_WE is decoded from state only, so it drops the instant reset asserts.
- Byte lanes are little-endian:
  - byte k = addr[1:0] occupies bits [8k+7:8k].
  - half h = addr[1] occupies bits [16h+15:16h].
- Misalignment rules:
  - word access with addr[1:0]!=0.
  - half access with addr[0]!=0.
  - byte access never misaligned.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - On req=1, latch op/addr/wdata/pc.
  - Aligned request: go to ACCESS.
  - Misaligned request: set exc_adel (load) or exc_ades (store), go to RESP. No memory access occurs.
  - req=0: stay in IDLE.
- ACCESS (mem_A driven):
  - Load: rdata <= extend(select(mem_RD)); go to RESP.
    - lh/lb sign-extend; lhu/lbu zero-extend; lw takes the full word.
  - sw: mem_WE=1, mem_WD=wdata; go to RESP.
  - sh/sb: buffer <= mem_RD; go to WRITE.
- WRITE:
  - mem_WE=1.
  - mem_WD = buffer with the selected lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged.
  - Go to RESP.
- RESP:
  - done=1 for exactly one cycle; exc flags valid.
  - Go to IDLE; exc flags clear on leaving RESP.
- Latency, counted from the req edge to done high:
  - aligned lw/lh/lhu/lb/lbu/sw: 2 cycles.
  - sh/sb: 3 cycles.
  - misaligned access: 1 cycle.
- req while busy is ignored and is not queued; the CPU holds req until it sees done.
- Back-to-back: a req asserted in the RESP cycle is ignored; a new request is accepted in the following IDLE cycle.
- Reset during ACCESS or WRITE aborts the access. No partial write reaches memory unless the WRITE clock edge has already completed.
- Writes only occur in ACCESS (sw) or WRITE (sh/sb); mem_WE is never high in IDLE or RESP.

Test Plan:
- Reset then lw:
  - Preload mem word 0x10 = 0x8899AABB.
  - req op=000 addr=0x10.
  - Expected: done exactly 2 cycles later, rdata=0x8899AABB, mem_WE never high.
- Sub-word loads on word 0x8899AABB at 0x10:
  - lb 0x13 -> 0xFFFFFF88.
  - lbu 0x13 -> 0x00000088.
  - lh 0x10 -> 0xFFFFAABB.
  - lhu 0x12 -> 0x00008899.
- sb read-modify-write:
  - Word at 0x20 = 0x11223344; sb addr=0x21 wdata=0xFFFFFF5A.
  - Expected: one mem_WE pulse with mem_WD=0x1122_5A44, mem_pc=pc; done 3 cycles after req.
- sh to upper half:
  - sh addr=0x22 wdata=0x0000BEEF on word 0x11223344.
  - Expected: mem_WD=0xBEEF3344.
- Misaligned accesses:
  - lw addr=0x11 -> done after 1 cycle with exc_adel=1, no memory access.
  - sh addr=0x23 -> exc_ades=1 and mem_WE stays 0 throughout.
- Reset mid-RMW and req while busy:
  - Assert reset during the WRITE state of an sb.
  - Expected: mem_WE drops immediately, memory word unchanged, all outputs 0.
  - Separately, pulse req while busy -> no second transaction is started.
